// File: rtl/cpu_oci_dct_pkg.sv
// cpu_oci_dct_pkg
//   Shared constants and state type for the OCI debug-capture trace unpacker.
//   DCT_NSYM is the number of symbol slots in one packed buffer.
package cpu_oci_dct_pkg;

  localparam int DCT_BUF_W = 30;
  localparam int DCT_SYM_W = 2;
  localparam int DCT_CNT_W = 4;
  localparam int DCT_NSYM  = DCT_BUF_W / DCT_SYM_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dct_state_t;

endpackage

// File: rtl/cpu_oci_sat_counter.sv
// cpu_oci_sat_counter
//   Free-running up counter with increment enable that sticks at all-ones
//   instead of wrapping.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset, clears the count
//   i_inc   - add one this cycle (ignored once saturated)
//   o_count - current count
module cpu_oci_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_count <= '0;
    else if (i_inc && (r_count != '1))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_oci_dct_unpacker.sv
// cpu_oci_dct_unpacker
//   Captures one packed trace buffer on a load strobe and replays its symbols,
//   oldest first, one per accepted beat on a valid/ready stream.
// Ports:
//   clk, reset      - clock (rising edge), asynchronous active-high reset
//   dct_buffer      - packed symbols, symbol k at [SYM_W*k +: SYM_W], k=0 oldest
//   dct_count       - number of valid symbols in dct_buffer
//   dct_load        - single-cycle capture strobe
//   dct_ready       - idle and able to capture
//   test_has_ended  - flush; holds the block idle while high
//   sym_data/valid/ready/last - output symbol stream
//   overrun         - sticky: a load arrived while busy
//   sym_total       - saturating count of accepted symbols
// BUF_W must be a multiple of SYM_W and 2**CNT_W-1 must cover BUF_W/SYM_W.
module cpu_oci_dct_unpacker
  import cpu_oci_dct_pkg::*;
#(
  parameter int BUF_W = DCT_BUF_W,
  parameter int SYM_W = DCT_SYM_W,
  parameter int CNT_W = DCT_CNT_W,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BUF_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0] dct_count,
  input  logic             dct_load,
  output logic             dct_ready,
  input  logic             test_has_ended,
  output logic [SYM_W-1:0] sym_data,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             sym_last,
  output logic             overrun,
  output logic [TOT_W-1:0] sym_total
);

  dct_state_t       r_state;
  logic [BUF_W-1:0] r_shift;
  logic [CNT_W-1:0] r_remaining;
  logic             r_overrun;
  logic             w_beat;

  // Outputs are decoded straight from registers, so an asynchronous reset
  // drops them immediately without waiting for an edge.
  assign dct_ready = (r_state == IDLE) && !test_has_ended;
  assign sym_valid = (r_state == SEND);
  assign sym_data  = r_shift[SYM_W-1:0];
  assign sym_last  = (r_state == SEND) && (r_remaining == CNT_W'(1));
  assign overrun   = r_overrun;

  // A handshake during flush is not a delivered symbol.
  assign w_beat = sym_valid && sym_ready && !test_has_ended;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_remaining <= '0;
      r_overrun   <= 1'b0;
    end else begin
      // Loads that collide with a busy buffer are dropped but remembered;
      // loads during flush are dropped silently.
      if (dct_load && (r_state != IDLE) && !test_has_ended)
        r_overrun <= 1'b1;

      if (test_has_ended) begin
        r_state     <= IDLE;
        r_shift     <= '0;
        r_remaining <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (dct_load && (dct_count != '0)) begin
              r_shift     <= dct_buffer;
              r_remaining <= dct_count;
              r_state     <= SEND;
            end
          end
          SEND: begin
            if (w_beat) begin
              r_shift     <= r_shift >> SYM_W;
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining == CNT_W'(1))
                r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  cpu_oci_sat_counter #(
    .W(TOT_W)
  ) u_total (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_inc  (w_beat),
    .o_count(sym_total)
  );

endmodule

// File: tb/tb_cpu_oci_dct_unpacker.sv
// Scoreboarded bench for cpu_oci_dct_unpacker: directed loads push expected
// {data,last} beats into a queue; a negedge monitor pops and compares on every
// accepted beat and checks stall stability.
module tb_cpu_oci_dct_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_load;
  logic        dct_ready;
  logic        test_has_ended;
  logic [1:0]  sym_data;
  logic        sym_valid;
  logic        sym_ready;
  logic        sym_last;
  logic        overrun;
  logic [15:0] sym_total;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_total = 0;
  logic [2:0] exp_q[$];   // {last, data}

  always #5 clk = ~clk;

  cpu_oci_dct_unpacker dut (
    .clk           (clk),
    .reset         (reset),
    .dct_buffer    (dct_buffer),
    .dct_count     (dct_count),
    .dct_load      (dct_load),
    .dct_ready     (dct_ready),
    .test_has_ended(test_has_ended),
    .sym_data      (sym_data),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .sym_last      (sym_last),
    .overrun       (overrun),
    .sym_total     (sym_total)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic load(input logic [29:0] buf_v, input logic [3:0] cnt);
    dct_buffer = buf_v;
    dct_count  = cnt;
    dct_load   = 1'b1;
    tick();
    dct_load   = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!sym_valid) break;
      tick();
    end
    check("drain_done", {31'd0, sym_valid}, 32'd0);
  endtask

  // Monitor: compare every counted beat, and hold data/last stable while stalled.
  initial begin
    logic       hold_v;
    logic [2:0] held;
    logic [2:0] e;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!reset && sym_valid && !test_has_ended) begin
        if (hold_v)
          check("stall_stable", {29'd0, sym_last, sym_data}, {29'd0, held});
        if (sym_ready) begin
          hold_v = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {29'd0, sym_last, sym_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat", {29'd0, sym_last, sym_data}, {29'd0, e});
          end
        end else begin
          hold_v = 1'b1;
          held   = {sym_last, sym_data};
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1;
    dct_buffer = '0;
    dct_count = '0;
    dct_load = 1'b0;
    test_has_ended = 1'b0;
    sym_ready = 1'b1;
    #12;
    reset = 1'b0;
    #1;
    // Reset state
    check("rst_valid", {31'd0, sym_valid}, 32'd0);
    check("rst_data",  {30'd0, sym_data},  32'd0);
    check("rst_last",  {31'd0, sym_last},  32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_total", {16'd0, sym_total}, 32'd0);
    check("rst_ready", {31'd0, dct_ready}, 32'd1);

    // 1) three symbols 3,2,1 with ready held high
    tick();
    push(2'd3, 1'b0); push(2'd2, 1'b0); push(2'd1, 1'b1);
    load(30'h0000_001B, 4'd3);
    check("t1_latency_valid", {31'd0, sym_valid}, 32'd1);
    check("t1_busy_ready", {31'd0, dct_ready}, 32'd0);
    tick(); tick(); tick();
    exp_total += 3;
    check("t1_ready_back", {31'd0, dct_ready}, 32'd1);
    check("t1_valid_off", {31'd0, sym_valid}, 32'd0);
    check("t1_total", {16'd0, sym_total}, exp_total);

    // 2) fifteen symbols, ready toggling
    for (int i = 0; i < 15; i++) push(2'd3, i == 14);
    sym_ready = 1'b1;
    load(30'h3FFF_FFFF, 4'd15);
    for (int i = 0; i < 40; i++) begin
      if (!sym_valid) break;
      tick();
      sym_ready = ~sym_ready;
    end
    check("t2_done", {31'd0, sym_valid}, 32'd0);
    exp_total += 15;
    check("t2_total", {16'd0, sym_total}, exp_total);
    sym_ready = 1'b1;
    tick();

    // 3) count-0 load is ignored
    load(30'h0000_001B, 4'd0);
    check("t3_valid", {31'd0, sym_valid}, 32'd0);
    check("t3_overrun", {31'd0, overrun}, 32'd0);
    check("t3_ready", {31'd0, dct_ready}, 32'd1);
    tick();
    check("t3_valid2", {31'd0, sym_valid}, 32'd0);

    // 4) flush after 2 of 5 symbols (0,1,2,3,1); load during flush ignored
    push(2'd0, 1'b0); push(2'd1, 1'b0);
    load(30'h0000_01E4, 4'd5);
    tick(); tick();
    test_has_ended = 1'b1;
    dct_buffer = 30'h0000_0003;
    dct_count = 4'd1;
    dct_load = 1'b1;
    tick();
    dct_load = 1'b0;
    exp_total += 2;
    check("t4_valid_off", {31'd0, sym_valid}, 32'd0);
    check("t4_total", {16'd0, sym_total}, exp_total);
    check("t4_no_overrun", {31'd0, overrun}, 32'd0);
    check("t4_ready_held", {31'd0, dct_ready}, 32'd0);
    dct_count = 4'd3;
    dct_load = 1'b1;
    tick();
    dct_load = 1'b0;
    check("t4_load_ignored", {31'd0, sym_valid}, 32'd0);
    test_has_ended = 1'b0;
    #1;
    check("t4_ready_after", {31'd0, dct_ready}, 32'd1);
    tick();
    push(2'd2, 1'b1);
    load(30'h0000_0002, 4'd1);
    drain(5);
    exp_total += 1;
    check("t4_total2", {16'd0, sym_total}, exp_total);

    // 5) load during SEND sets overrun, original buffer completes
    push(2'd3, 1'b0); push(2'd2, 1'b0); push(2'd1, 1'b1);
    load(30'h0000_001B, 4'd3);
    sym_ready = 1'b0;
    tick();
    load(30'h0AAA_AAAA, 4'd2);
    check("t5_overrun_set", {31'd0, overrun}, 32'd1);
    sym_ready = 1'b1;
    drain(10);
    tick(); tick();
    exp_total += 3;
    check("t5_overrun_sticky", {31'd0, overrun}, 32'd1);
    check("t5_total", {16'd0, sym_total}, exp_total);
    check("t5_no_second", {31'd0, sym_valid}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    // 6) asynchronous reset mid-SEND, off the clock edge
    sym_ready = 1'b0;
    load(30'h0000_001B, 4'd3);
    tick();
    check("t6_in_send", {31'd0, sym_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", {31'd0, sym_valid}, 32'd0);
    check("t6_data",  {30'd0, sym_data},  32'd0);
    check("t6_last",  {31'd0, sym_last},  32'd0);
    check("t6_overrun", {31'd0, overrun}, 32'd0);
    check("t6_total", {16'd0, sym_total}, 32'd0);
    check("t6_ready", {31'd0, dct_ready}, 32'd1);
    #2;
    reset = 1'b0;
    sym_ready = 1'b1;
    tick(); tick();
    check("t6_stays_idle", {31'd0, sym_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
